// File: rtl/mux_sel_serializer.sv
// -----------------------------------------------------------------------------
// mux_sel_serializer
//
// Parametrised N_IN:1 word selector with a registered output and a scan mode
// that snapshots all inputs and streams them out one word per handshake.
//
//   DIRECT (mode=0, IDLE): out_data <= word[sel] every cycle (0 when sel is out
//                          of range, flagged on sel_err); out_valid held high.
//   SCAN   (start in IDLE with mode=1): all words are captured into a shadow
//                          register and emitted word 0..N_IN-1 under
//                          out_valid/out_ready, with last on the final word.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_data    in   N_IN*W   flattened input words, word k = in_data[k*W +: W]
//   sel        in   SEL_W    DIRECT-mode word index
//   mode       in   1        0 = DIRECT, 1 = SCAN (sampled only in IDLE)
//   start      in   1        SCAN trigger pulse (honoured only in IDLE, mode=1)
//   out_data   out  W        registered selected / serialised word
//   out_valid  out  1        out_data valid
//   out_ready  in   1        downstream accept (SCAN only)
//   last       out  1        high with the final SCAN word
//   busy       out  1        high while scanning
//   sel_err    out  1        registered flag: sel >= N_IN in DIRECT
// -----------------------------------------------------------------------------
module mux_sel_serializer #(
  parameter int N_IN  = 24,
  parameter int W     = 1,
  parameter int SEL_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                start,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                last,
  output logic                busy,
  output logic                sel_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   N_IN_X   = (SEL_W + 1)'(N_IN);

  state_t              state_q,     state_d;
  logic [SEL_W-1:0]    idx_q,       idx_d;
  logic [N_IN*W-1:0]   shadow_q,    shadow_d;
  logic [W-1:0]        out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                last_q,      last_d;
  logic                busy_q,      busy_d;
  logic                sel_err_q,   sel_err_d;
  logic [SEL_W-1:0]    idx_next;

  // Word lookup by explicit compare so an out-of-range index yields 0, not X.
  function automatic logic [W-1:0] pick_word(input logic [N_IN*W-1:0] words,
                                             input logic [SEL_W-1:0]  index);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_IN; k++) begin
      if ({1'b0, index} == (SEL_W + 1)'(k)) r = words[k*W +: W];
    end
    return r;
  endfunction

  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] index);
    return ({1'b0, index} >= N_IN_X);
  endfunction

  assign idx_next = idx_q + SEL_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    sel_err_d   = sel_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!mode) begin
          out_data_d  = pick_word(in_data, sel);
          sel_err_d   = sel_out_of_range(sel);
          out_valid_d = 1'b1;
          last_d      = 1'b0;
        end else if (start) begin
          // Word 0 is taken straight from in_data so it appears on the same
          // edge the shadow is loaded; N_IN >= 2 means it is never the last.
          shadow_d    = in_data;
          idx_d       = '0;
          state_d     = ST_SCAN;
          busy_d      = 1'b1;
          out_data_d  = pick_word(in_data, '0);
          out_valid_d = 1'b1;
          last_d      = 1'b0;
          sel_err_d   = 1'b0;
        end else begin
          out_valid_d = 1'b0;
          sel_err_d   = 1'b0;
          last_d      = 1'b0;
        end
      end

      ST_SCAN: begin
        sel_err_d   = 1'b0;
        out_valid_d = 1'b1;
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            // Zero-bubble: the next word is loaded on the accepting edge.
            idx_d      = idx_next;
            out_data_d = pick_word(shadow_q, idx_next);
            last_d     = (idx_next == LAST_IDX);
          end else begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            idx_d       = '0;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register stage: all outputs and scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
module tb_mux_sel_serializer;

  localparam int N_IN  = 24;
  localparam int W     = 8;
  localparam int SEL_W = 5;

  logic                clk;
  logic                rst;
  logic [N_IN*W-1:0]   in_data;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic                start;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic                last;
  logic                busy;
  logic                sel_err;

  mux_sel_serializer #(.N_IN(N_IN), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .start     (start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of words still owed to the consumer while
  // scanning; empty queue means idle.
  logic [W-1:0] pend_q[$];
  logic [W-1:0] exp_data;
  logic         exp_valid, exp_last, exp_busy, exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [N_IN*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  task automatic fill_base(input int base);
    for (int k = 0; k < N_IN; k++) in_data[k*W +: W] = W'(base + k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N_IN; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  task automatic model_edge();
    if (rst) begin
      exp_data = '0; exp_valid = 0; exp_last = 0; exp_busy = 0; exp_err = 0;
      pend_q.delete();
    end else if (pend_q.size() > 0) begin
      exp_err = 0;
      if (out_ready) begin
        void'(pend_q.pop_front());
        if (pend_q.size() == 0) begin
          exp_valid = 0; exp_last = 0; exp_busy = 0;
        end else begin
          exp_data = pend_q[0];
          exp_last = (pend_q.size() == 1);
        end
      end
    end else if (!mode) begin
      exp_data  = (int'(sel) < N_IN) ? word_of(in_data, int'(sel)) : '0;
      exp_err   = (int'(sel) >= N_IN);
      exp_valid = 1; exp_last = 0;
    end else if (start) begin
      for (int k = 0; k < N_IN; k++) pend_q.push_back(word_of(in_data, k));
      exp_data = pend_q[0]; exp_valid = 1; exp_busy = 1;
      exp_last = (pend_q.size() == 1); exp_err = 0;
    end else begin
      exp_valid = 0; exp_err = 0; exp_last = 0;
    end
  endtask

  // One clock: model the edge with the inputs the DUT sampled, then check.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".data"},  64'(out_data),  64'(exp_data));
    chk({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
    chk({tag, ".last"},  64'(last),      64'(exp_last));
    chk({tag, ".busy"},  64'(busy),      64'(exp_busy));
    chk({tag, ".err"},   64'(sel_err),   64'(exp_err));
  endtask

  int acc;
  int guard;

  initial begin
    exp_data = '0; exp_valid = 0; exp_last = 0; exp_busy = 0; exp_err = 0;
    rst = 1; mode = $urandom; start = $urandom; sel = SEL_W'($urandom);
    out_ready = $urandom; fill_random();

    // Reset held two cycles with arbitrary inputs
    step("rst0");
    mode = 1; start = 1; fill_random();
    step("rst1");

    // Release into DIRECT with word3 = 1
    rst = 0; mode = 0; start = 0; sel = 3; fill_random();
    in_data[3*W +: W] = 8'h01;
    step("rel");
    chk("rel.word3", 64'(out_data), 64'h01);

    // DIRECT sweep including out-of-range select
    fill_base('h10);
    for (int s = 0; s < 32; s++) begin
      sel = SEL_W'(s);
      step("dir");
      chk("dir.sweep", 64'(out_data), (s < N_IN) ? 64'(s + 'h10) : 64'h0);
    end
    for (int i = 0; i < 20; i++) begin
      sel = SEL_W'($urandom); fill_random(); out_ready = $urandom;
      step("dir_rnd");
    end

    // SCAN at full rate
    fill_base('h40); mode = 1; start = 0; out_ready = 1;
    step("idle");
    start = 1;
    step("scan_go");
    start = 0; fill_random();
    acc = 0;
    guard = 0;
    while (exp_busy && guard < 60) begin
      if (out_valid && out_ready && last) chk("scan.last_word", 64'(out_data), 64'h57);
      acc++;
      step("scan");
      guard++;
    end
    chk("scan.cycles", 64'(acc), 64'(N_IN));

    // Backpressure at idx 5 with in_data changing underneath
    fill_base('h40); start = 1;
    step("bp_go");
    start = 0;
    guard = 0;
    while (exp_data != 8'h45 && guard < 30) begin step("bp_run"); guard++; end
    chk("bp.reach", 64'(out_data), 64'h45);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      fill_random();
      step("bp_hold");
      chk("bp.held", 64'(out_data), 64'h45);
    end
    out_ready = 1;
    step("bp_resume");
    chk("bp.next", 64'(out_data), 64'h46);
    guard = 0;
    while (exp_busy && guard < 60) begin step("bp_tail"); guard++; end

    // Start collisions: mid-scan and on the final-accept cycle
    fill_base('h80); start = 1;
    step("col_go");
    acc = 0;
    guard = 0;
    while (exp_busy && guard < 60) begin
      start = (guard == 7) || (pend_q.size() == 1);
      if (busy && out_valid && out_ready) acc++;
      fill_random();
      step("col");
      guard++;
    end
    chk("col.count", 64'(acc), 64'(N_IN));
    start = 0; fill_base('h20);
    step("col_idle");
    start = 1;
    step("col_restart");
    chk("col.word0", 64'(out_data), 64'h20);
    start = 0;
    guard = 0;
    while (exp_busy && guard < 60) begin step("col_tail"); guard++; end

    // Reset in the middle of a scan
    fill_base('h60); start = 1;
    step("mr_go");
    start = 0;
    guard = 0;
    while (exp_data != 8'h6A && guard < 30) begin step("mr_run"); guard++; end
    rst = 1;
    step("mr_rst");
    chk("mr.valid", 64'(out_valid), 64'h0);
    rst = 0; start = 1; fill_base('h30);
    step("mr_rescan");
    chk("mr.word0", 64'(out_data), 64'h30);
    start = 0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      mode      = ($urandom_range(0, 99) < 70);
      start     = ($urandom_range(0, 99) < 30);
      out_ready = ($urandom_range(0, 99) < 70);
      sel       = SEL_W'($urandom);
      fill_random();
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
